// File: rtl/ws2812_unipolar_rz_decoder_if.sv
// Single-wire RZ line plus decoded bit/pixel/status strobes of the WS2812 decoder.
// master: line driver and result consumer; slave: the decoder itself.
interface ws2812_unipolar_rz_decoder_if;
  logic        din;
  logic        bit_data;
  logic        bit_valid;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_reset;
  logic        error;

  modport master (
    output din,
    input  bit_data,
    input  bit_valid,
    input  pixel_data,
    input  pixel_valid,
    input  frame_reset,
    input  error
  );

  modport slave (
    input  din,
    output bit_data,
    output bit_valid,
    output pixel_data,
    output pixel_valid,
    output frame_reset,
    output error
  );
endinterface

// File: rtl/ws2812_unipolar_rz_decoder.sv
// WS2812 RZ line decoder: measures high-pulse widths, recovers bits MSB-first
// into 24-bit pixels, and flags reset gaps and malformed pulses.
module ws2812_unipolar_rz_decoder #(
  parameter int unsigned CLK_FREQ_KHZ       = 50000,
  parameter int unsigned T_HI_MIN_NS        = 100,
  parameter int unsigned T_BIT_THRESHOLD_NS = 500,
  parameter int unsigned T_HI_MAX_NS        = 1000,
  parameter int unsigned T_RESET_NS         = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ws2812_unipolar_rz_decoder_if.slave  bus
);

  localparam int unsigned CLK_PERIOD_PS = 1_000_000_000 / CLK_FREQ_KHZ;
  localparam int unsigned HI_MIN_TICKS  = (T_HI_MIN_NS * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  localparam int unsigned THR_TICKS     = (T_BIT_THRESHOLD_NS * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  localparam int unsigned HI_MAX_TICKS  = (T_HI_MAX_NS * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  localparam int unsigned RESET_TICKS   = (T_RESET_NS * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  localparam int unsigned CNT_W         = $clog2(RESET_TICKS + 1);

  localparam logic [CNT_W-1:0] HI_MIN_C = CNT_W'(HI_MIN_TICKS);
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THR_TICKS);
  localparam logic [CNT_W-1:0] HI_MAX_C = CNT_W'(HI_MAX_TICKS);
  localparam logic [CNT_W-1:0] HI_SAT_C = CNT_W'(HI_MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_TICKS);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } state_e;

  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic             gap_hit;

  state_e       state_q, state_d;
  logic [4:0]   bit_cnt_q, bit_cnt_d;
  logic [22:0]  shift_q, shift_d;
  logic         bit_data_q, bit_data_d;
  logic         bit_valid_q, bit_valid_d;
  logic [23:0]  pixel_data_q, pixel_data_d;
  logic         pixel_valid_q, pixel_valid_d;
  logic         frame_reset_q, frame_reset_d;
  logic         error_q, error_d;
  logic         w_bit;
  logic         w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_comb begin
    hi_cnt_d = '0;
    lo_cnt_d = '0;
    if (s2_q) begin
      hi_cnt_d = (hi_cnt_q != HI_SAT_C) ? hi_cnt_q + 1'b1 : hi_cnt_q;
    end else begin
      lo_cnt_d = (lo_cnt_q != RESET_C) ? lo_cnt_q + 1'b1 : lo_cnt_q;
    end
  end

  // Decided one cycle early so the registered strobe lands in the cycle lo_cnt first equals RESET_TICKS.
  assign gap_hit = (lo_cnt_d == RESET_C) && (lo_cnt_q != RESET_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  assign w_bit = (hi_cnt_q >= THR_C);
  assign w_bad = (hi_cnt_q < HI_MIN_C) || (hi_cnt_q > HI_MAX_C);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    bit_data_d    = bit_data_q;
    pixel_data_d  = pixel_data_q;
    bit_valid_d   = 1'b0;
    pixel_valid_d = 1'b0;
    frame_reset_d = 1'b0;
    error_d       = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (gap_hit) begin
          frame_reset_d = 1'b1;
          bit_cnt_d     = '0;
          state_d       = IDLE;
        end
      end
      IDLE: begin
        if (rise) state_d = HIGH;
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (gap_hit) begin
          frame_reset_d = 1'b1;
          state_d       = IDLE;
          if (bit_cnt_q != '0) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      HIGH: begin
        // Over-long highs are only judged at the fall, so a stuck-high line stays silent.
        if (fall) begin
          if (w_bad) begin
            error_d = 1'b1;
            state_d = SYNC;
          end else begin
            bit_valid_d = 1'b1;
            bit_data_d  = w_bit;
            shift_d     = {shift_q[21:0], w_bit};
            state_d     = LOW;
            if (bit_cnt_q == 5'd23) begin
              pixel_data_d  = {shift_q, w_bit};
              pixel_valid_d = 1'b1;
              bit_cnt_d     = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      bit_data_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_reset_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      bit_data_q    <= bit_data_d;
      bit_valid_q   <= bit_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      frame_reset_q <= frame_reset_d;
      error_q       <= error_d;
    end
  end

  assign bus.bit_data    = bit_data_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.frame_reset = frame_reset_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_ws2812_unipolar_rz_decoder.sv
// Bench for the WS2812 RZ decoder: drives pulse trains and checks decoded
// events against a pulse-level model of the line protocol.
module tb_ws2812_unipolar_rz_decoder;

  localparam int R_TICKS = 2500;
  localparam int MIN_W   = 5;
  localparam int THR_W   = 25;
  localparam int MAX_W   = 50;

  logic clk;
  logic rst_n;
  int   cyc;

  ws2812_unipolar_rz_decoder_if bus ();

  ws2812_unipolar_rz_decoder #(
    .CLK_FREQ_KHZ      (50000),
    .T_HI_MIN_NS       (100),
    .T_BIT_THRESHOLD_NS(500),
    .T_HI_MAX_NS       (1000),
    .T_RESET_NS        (50000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  logic        obs_bits[$];
  logic [23:0] obs_pix[$];
  int obs_fr, obs_err, obs_err_fr, obs_bv_fr, obs_pv_alone;
  int last_bv_cyc, last_fr_cyc;

  always @(negedge clk) begin
    if (bus.bit_valid) begin
      obs_bits.push_back(bus.bit_data);
      last_bv_cyc <= cyc;
    end
    if (bus.pixel_valid) obs_pix.push_back(bus.pixel_data);
    if (bus.frame_reset) begin
      obs_fr      <= obs_fr + 1;
      last_fr_cyc <= cyc;
    end
    if (bus.error) obs_err <= obs_err + 1;
    if (bus.error && bus.frame_reset) obs_err_fr <= obs_err_fr + 1;
    if (bus.bit_valid && bus.frame_reset) obs_bv_fr <= obs_bv_fr + 1;
    if (bus.pixel_valid && !bus.bit_valid) obs_pv_alone <= obs_pv_alone + 1;
  end

  // Pulse-level model: 0 = awaiting reset gap, 1 = just reset, 2 = receiving bits
  int          m_state;
  int          m_nbits;
  logic [23:0] m_shift;
  int          lo_acc;
  logic        exp_bits[$];
  logic [23:0] exp_pix[$];
  int exp_fr, exp_err, exp_err_fr;
  int bit_ptr, pix_ptr;

  int n_asserts, n_fail;
  int fall_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset_gap();
    if (m_state == 0) begin
      exp_fr++;
      m_nbits = 0;
      m_state = 1;
    end else if (m_state == 2) begin
      exp_fr++;
      if (m_nbits != 0) begin
        exp_err++;
        exp_err_fr++;
      end
      m_nbits = 0;
      m_state = 1;
    end
  endtask

  task automatic model_low(input int n);
    int prev;
    prev   = lo_acc;
    lo_acc = lo_acc + n;
    if (prev < R_TICKS && lo_acc >= R_TICKS) model_reset_gap();
  endtask

  task automatic model_pulse(input int w);
    logic b;
    lo_acc = 0;
    if (m_state != 0) begin
      if (w < MIN_W || w > MAX_W) begin
        exp_err++;
        m_state = 0;
      end else begin
        b = (w >= THR_W);
        exp_bits.push_back(b);
        m_shift = {m_shift[22:0], b};
        m_nbits++;
        if (m_nbits == 24) begin
          exp_pix.push_back(m_shift);
          m_nbits = 0;
        end
        m_state = 2;
      end
    end
  endtask

  task automatic send_pulse(input int hi, input int lo);
    bus.din = 1'b1;
    model_pulse(hi);
    repeat (hi) @(negedge clk);
    bus.din  = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(negedge clk);
    model_low(lo);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    model_low(n);
  endtask

  task automatic send_bits(input logic [23:0] data, input int first, input int last, input bit rnd);
    logic b;
    for (int i = first; i >= last; i--) begin
      b = data[i];
      if (rnd)
        send_pulse(b ? $urandom_range(MAX_W, THR_W) : $urandom_range(THR_W - 1, MIN_W),
                   $urandom_range(60, 1));
      else
        send_pulse(b ? 35 : 15, b ? 20 : 40);
    end
  endtask

  task automatic check_all(input string tag);
    idle(5);
    #2;
    chk({tag, " bit count"}, obs_bits.size(), exp_bits.size());
    for (int i = bit_ptr; i < obs_bits.size() && i < exp_bits.size(); i++)
      chk($sformatf("%s bit%0d", tag, i), {31'd0, obs_bits[i]}, {31'd0, exp_bits[i]});
    bit_ptr = exp_bits.size();
    chk({tag, " pixel count"}, obs_pix.size(), exp_pix.size());
    for (int i = pix_ptr; i < obs_pix.size() && i < exp_pix.size(); i++)
      chk($sformatf("%s pixel%0d", tag, i), {8'd0, obs_pix[i]}, {8'd0, exp_pix[i]});
    pix_ptr = exp_pix.size();
    chk({tag, " frame_reset count"}, obs_fr, exp_fr);
    chk({tag, " error count"}, obs_err, exp_err);
    chk({tag, " error+frame_reset"}, obs_err_fr, exp_err_fr);
    chk({tag, " bit_valid+frame_reset"}, obs_bv_fr, 0);
    chk({tag, " pixel_valid w/o bit_valid"}, obs_pv_alone, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " bit_data"}, {31'd0, bus.bit_data}, 0);
    chk({tag, " bit_valid"}, {31'd0, bus.bit_valid}, 0);
    chk({tag, " pixel_data"}, {8'd0, bus.pixel_data}, 0);
    chk({tag, " pixel_valid"}, {31'd0, bus.pixel_valid}, 0);
    chk({tag, " frame_reset"}, {31'd0, bus.frame_reset}, 0);
    chk({tag, " error"}, {31'd0, bus.error}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] rnd_pix;

  initial begin
    m_state = 0; m_nbits = 0; m_shift = '0; lo_acc = 0;
    rst_n   = 1'b0;
    bus.din = 1'b0;
    repeat (5) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // No reset gap seen yet: a full pixel must be ignored
    idle(10);
    send_bits(24'h5A5A5A, 23, 0, 1'b0);
    check_all("unsynced");
    idle(2600);
    check_all("first gap");

    send_bits(24'hA5C3F0, 23, 0, 1'b0);
    chk("bit latency", last_bv_cyc - fall_cyc, 3);
    check_all("A5C3F0");
    chk("pixel held", {8'd0, bus.pixel_data}, 32'h00A5C3F0);

    send_bits(24'hFFFFFF, 23, 0, 1'b0);
    send_bits(24'h000000, 23, 1, 1'b0);
    send_pulse(15, 3000);
    chk("frame_reset latency", last_fr_cyc - fall_cyc, R_TICKS + 2);
    check_all("FF/00 pixels");

    send_pulse(24, 30);
    send_pulse(25, 30);
    send_pulse(50, 30);
    send_pulse(51, 30);
    send_pulse(35, 20);
    send_pulse(15, 40);
    send_pulse(35, 20);
    check_all("boundary widths");
    idle(2600);
    check_all("resync after long high");
    send_pulse(4, 30);
    idle(2600);
    check_all("glitch");

    send_bits(24'h123456, 23, 14, 1'b0);
    idle(2600);
    check_all("partial pixel");
    send_bits(24'h123456, 23, 0, 1'b0);
    check_all("123456");

    for (int p = 0; p < 3; p++) begin
      rnd_pix = 24'($urandom);
      send_bits(rnd_pix, 23, 0, 1'b1);
    end
    idle(2600);
    check_all("random pixels");

    // Reset pulse in the middle of the 12th bit
    rnd_pix = 24'($urandom);
    send_bits(rnd_pix, 23, 13, 1'b1);
    check_all("pre-reset bits");
    bus.din = 1'b1;
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_outputs_zero("async reset");
    @(negedge clk);
    rst_n   = 1'b1;
    m_state = 0;
    m_nbits = 0;
    model_pulse(30);
    repeat (20) @(negedge clk);
    bus.din = 1'b0;
    idle(30);
    send_bits(rnd_pix, 11, 0, 1'b1);
    check_all("after reset");
    idle(2600);
    rnd_pix = 24'($urandom);
    send_bits(rnd_pix, 23, 0, 1'b1);
    check_all("post-reset pixel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
